// File: rtl/pixel_write_arbiter_if.sv
// Requester-side pixel bus shared by the drawing engines and the frame-buffer write arbiter.
// Handshake: a beat transfers on a cycle where req_valid[i] && req_ready[i]; the requester holds
// valid, last and pixel data stable until then, and the arbiter never retracts ready within a cycle.
interface pixel_write_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [9*NUM_REQ-1:0] req_x;
    logic [8*NUM_REQ-1:0] req_y;
    logic [3*NUM_REQ-1:0] req_color;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (
        output req_valid, req_last, req_x, req_y, req_color,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_last, req_x, req_y, req_color,
        output req_ready
    );
endinterface

// File: rtl/pixel_write_arbiter.sv
// Round-robin, burst-locked arbiter for the VGA adapter's single pixel write port.
// Accepted on-screen pixels are registered onto vga_*; off-screen pixels are counted and dropped.
module pixel_write_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 1023,
    parameter int SCREEN_W     = 320,
    parameter int SCREEN_H     = 240
) (
    input  logic                 clk,
    input  logic                 rst,
    pixel_write_arbiter_if.slave req_if,
    output logic [8:0]           vga_x,
    output logic [7:0]           vga_y,
    output logic [2:0]           vga_color,
    output logic                 vga_plot,
    output logic                 busy,
    output logic [2:0]           owner,
    output logic [15:0]          drop_cnt,
    output logic                 timeout_err,
    output logic                 dbg_state
);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [2:0]       owner_q, owner_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [8:0]       vga_x_q, vga_x_d;
    logic [7:0]       vga_y_q, vga_y_d;
    logic [2:0]       vga_color_q, vga_color_d;
    logic             vga_plot_q, vga_plot_d;

    logic [NUM_REQ-1:0] ready;
    logic               hi_found, lo_found;
    logic [2:0]         hi_win, lo_win, win;
    logic               own_valid, own_last, win_last;
    logic               acc;
    logic [2:0]         acc_idx;
    logic [8:0]         sel_x;
    logic [7:0]         sel_y;
    logic [2:0]         sel_c;
    logic               on_screen;

    function automatic logic [2:0] next_idx(input logic [2:0] v);
        return (v == 3'(NUM_REQ - 1)) ? 3'd0 : v + 3'd1;
    endfunction

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_win   = 3'd0;
        lo_win   = 3'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_if.req_valid[i]) begin
                lo_found = 1'b1;
                lo_win   = 3'(i);
                if (3'(i) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_win   = 3'(i);
                end
            end
        end
        win = hi_found ? hi_win : lo_win;
    end

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        win_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == 3'(i)) begin
                own_valid = req_if.req_valid[i];
                own_last  = req_if.req_last[i];
            end
            if (win == 3'(i)) win_last = req_if.req_last[i];
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        idle_cnt_d    = idle_cnt_q;
        timeout_err_d = timeout_err_q;
        ready         = '0;
        acc           = 1'b0;
        acc_idx       = owner_q;
        case (state_q)
            IDLE: begin
                if (lo_found) begin
                    ready   = NUM_REQ'(1) << win;
                    acc     = 1'b1;
                    acc_idx = win;
                    owner_d = win;
                    if (win_last) begin
                        rr_ptr_d = next_idx(win);
                    end else begin
                        state_d    = LOCKED;
                        idle_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                // A counter already at the limit revokes this cycle, even if the owner's valid just returned.
                if (idle_cnt_q == CNT_W'(LOCK_TIMEOUT)) begin
                    state_d       = IDLE;
                    rr_ptr_d      = next_idx(owner_q);
                    timeout_err_d = 1'b1;
                end else if (own_valid) begin
                    ready      = NUM_REQ'(1) << owner_q;
                    acc        = 1'b1;
                    idle_cnt_d = '0;
                    if (own_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_idx(owner_q);
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_idx == 3'(i)) begin
                sel_x = req_if.req_x[9*i +: 9];
                sel_y = req_if.req_y[8*i +: 8];
                sel_c = req_if.req_color[3*i +: 3];
            end
        end
        on_screen = (32'(sel_x) < SCREEN_W) && (32'(sel_y) < SCREEN_H);
    end

    always_comb begin
        vga_x_d     = vga_x_q;
        vga_y_d     = vga_y_q;
        vga_color_d = vga_color_q;
        vga_plot_d  = 1'b0;
        drop_cnt_d  = drop_cnt_q;
        if (acc) begin
            if (on_screen) begin
                vga_plot_d  = 1'b1;
                vga_x_d     = sel_x;
                vga_y_d     = sel_y;
                vga_color_d = sel_c;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            owner_q       <= 3'd0;
            rr_ptr_q      <= 3'd0;
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            drop_cnt_q    <= 16'd0;
            vga_x_q       <= 9'd0;
            vga_y_q       <= 8'd0;
            vga_color_q   <= 3'd0;
            vga_plot_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= timeout_err_d;
            drop_cnt_q    <= drop_cnt_d;
            vga_x_q       <= vga_x_d;
            vga_y_q       <= vga_y_d;
            vga_color_q   <= vga_color_d;
            vga_plot_q    <= vga_plot_d;
        end
    end

    // Ready is gated by reset so no beat can be claimed while the flops are held.
    assign req_if.req_ready = rst ? ready : '0;
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_color   = vga_color_q;
    assign vga_plot    = vga_plot_q;
    assign busy        = (state_q == LOCKED);
    assign owner       = owner_q;
    assign drop_cnt    = drop_cnt_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state   = (state_q == LOCKED);
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed scenarios followed by randomized multi-requester traffic, checked cycle by cycle
// against a behavioural arbiter model and a queue of expected plotted pixels.
module tb_pixel_write_arbiter;
    localparam int N  = 4;
    localparam int LT = 1023;
    localparam int SW = 320;
    localparam int SH = 240;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pixel_write_arbiter_if #(.NUM_REQ(N)) bus ();

    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_color;
    logic        vga_plot, busy, timeout_err, dbg_state;
    logic [2:0]  owner;
    logic [15:0] drop_cnt;

    pixel_write_arbiter #(
        .NUM_REQ(N), .LOCK_TIMEOUT(LT), .SCREEN_W(SW), .SCREEN_H(SH)
    ) dut (
        .clk(clk), .rst(rst), .req_if(bus),
        .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot),
        .busy(busy), .owner(owner), .drop_cnt(drop_cnt), .timeout_err(timeout_err),
        .dbg_state(dbg_state)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // requester drive state
    logic [N-1:0] v, l;
    logic [8:0]   px[N];
    logic [7:0]   py[N];
    logic [2:0]   pc[N];
    int           rem[N];

    // reference model state
    bit           m_locked, m_terr, m_plot;
    int           m_owner, m_rr, m_idle, m_drop, m_acc;
    logic [8:0]   m_x;
    logic [7:0]   m_y;
    logic [2:0]   m_c;
    logic [N-1:0] exp_ready, last_ready;
    logic [19:0]  exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid = v;
        bus.req_last  = l;
        for (int i = 0; i < N; i++) begin
            bus.req_x[9*i +: 9]     = px[i];
            bus.req_y[8*i +: 8]     = py[i];
            bus.req_color[3*i +: 3] = pc[i];
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_terr = 0; m_plot = 0;
        m_owner = 0; m_rr = 0; m_idle = 0; m_drop = 0; m_acc = -1;
        m_x = '0; m_y = '0; m_c = '0;
        exp_q.delete();
    endtask

    // One clock of the arbitration rules applied to the current inputs.
    task automatic model_step();
        int i;
        m_acc = -1;
        exp_ready = '0;
        if (!m_locked) begin
            for (int k = 0; k < N; k++) begin
                i = (m_rr + k) % N;
                if (v[i] && m_acc < 0) m_acc = i;
            end
            if (m_acc >= 0) begin
                m_owner = m_acc;
                if (l[m_acc]) m_rr = (m_acc + 1) % N;
                else begin m_locked = 1; m_idle = 0; end
            end
        end else if (m_idle >= LT) begin
            m_locked = 0; m_rr = (m_owner + 1) % N; m_terr = 1;
        end else if (v[m_owner]) begin
            m_acc = m_owner; m_idle = 0;
            if (l[m_owner]) begin m_locked = 0; m_rr = (m_owner + 1) % N; end
        end else begin
            m_idle++;
        end
        m_plot = 0;
        if (m_acc >= 0) begin
            exp_ready[m_acc] = 1'b1;
            if (int'(px[m_acc]) < SW && int'(py[m_acc]) < SH) begin
                exp_q.push_back({px[m_acc], py[m_acc], pc[m_acc]});
                m_plot = 1;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end
    endtask

    task automatic check_outputs();
        if (m_plot) {m_x, m_y, m_c} = exp_q.pop_front();
        chk("plot",    32'(vga_plot),    32'(m_plot));
        chk("busy",    32'(busy),        32'(m_locked));
        chk("state",   32'(dbg_state),   32'(m_locked));
        chk("owner",   32'(owner),       32'(m_owner));
        chk("drop",    32'(drop_cnt),    32'(m_drop));
        chk("terr",    32'(timeout_err), 32'(m_terr));
        chk("x",       32'(vga_x),       32'(m_x));
        chk("y",       32'(vga_y),       32'(m_y));
        chk("color",   32'(vga_color),   32'(m_c));
    endtask

    // Called just after a negedge with v/l/px/... already set.
    task automatic cycle();
        drive();
        #1;
        model_step();
        last_ready = bus.req_ready;
        chk("ready", 32'(last_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_plot"},  32'(vga_plot),     32'd0);
        chk({tag, "_x"},     32'(vga_x),        32'd0);
        chk({tag, "_y"},     32'(vga_y),        32'd0);
        chk({tag, "_color"}, 32'(vga_color),    32'd0);
        chk({tag, "_busy"},  32'(busy),         32'd0);
        chk({tag, "_owner"}, 32'(owner),        32'd0);
        chk({tag, "_drop"},  32'(drop_cnt),     32'd0);
        chk({tag, "_terr"},  32'(timeout_err),  32'd0);
        chk({tag, "_state"}, 32'(dbg_state),    32'd0);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        v = '0; l = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        drive();
        #1;
        check_reset_values("rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load_beat(input int i, input bit on_only);
        px[i] = on_only ? 9'($urandom_range(0, 319)) : 9'($urandom_range(0, 350));
        py[i] = on_only ? 8'($urandom_range(0, 239)) : 8'($urandom_range(0, 255));
        pc[i] = 3'($urandom_range(0, 7));
        l[i]  = (rem[i] == 1);
        v[i]  = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[12];
        int bl[N];
        seq = '{0, 0, 0, 2, 2, 2, 0, 0, 0, 2, 2, 2};
        v = '0; l = '0;
        for (int i = 0; i < N; i++) begin
            px[i] = 9'd100; py[i] = 8'd100; pc[i] = 3'd1; rem[i] = 0; bl[i] = 0;
        end
        model_reset();

        // Reset with all requesters valid, then release: requester 0 first.
        @(negedge clk);
        v = '1; l = '1;
        px[0] = 9'd10; py[0] = 8'd20; pc[0] = 3'b010;
        drive();
        #1;
        check_reset_values("t1_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cycle();
        chk("t1_grant", 32'(last_ready), 32'b0001);
        chk("t1_plot",  32'(vga_plot),   32'd1);
        chk("t1_x",     32'(vga_x),      32'd10);
        chk("t1_y",     32'(vga_y),      32'd20);
        chk("t1_color", 32'(vga_color),  32'b010);
        v = '0;

        // Requesters 0 and 2 stream back-to-back 3-beat bursts.
        do_reset();
        rem[0] = 3; rem[2] = 3; bl[0] = 1; bl[2] = 1;
        load_beat(0, 1); load_beat(2, 1);
        for (int k = 0; k < 12; k++) begin
            cycle();
            chk("t2_grant", 32'(last_ready), 32'(1 << seq[k]));
            if (m_acc >= 0) begin
                rem[m_acc]--;
                if (rem[m_acc] > 0) load_beat(m_acc, 1);
                else if (bl[m_acc] > 0) begin
                    bl[m_acc]--; rem[m_acc] = 3; load_beat(m_acc, 1);
                end else v[m_acc] = 1'b0;
            end
        end
        v = '0;
        cycle();

        // Off-screen filtering on requester 1.
        do_reset();
        v[1] = 1'b1; l[1] = 1'b1; pc[1] = 3'd5;
        px[1] = 9'd320; py[1] = 8'd0;
        cycle();
        chk("t3_plot_a", 32'(vga_plot), 32'd0);
        px[1] = 9'd0; py[1] = 8'd240;
        cycle();
        chk("t3_plot_b", 32'(vga_plot), 32'd0);
        px[1] = 9'd319; py[1] = 8'd239;
        cycle();
        chk("t3_plot_c", 32'(vga_plot), 32'd1);
        chk("t3_drop",   32'(drop_cnt), 32'd2);
        chk("t3_x",      32'(vga_x),    32'd319);
        chk("t3_y",      32'(vga_y),    32'd239);
        v = '0;

        // Requester 3 stalls mid-burst until the grant is revoked.
        do_reset();
        rem[3] = 2; load_beat(3, 1);
        cycle();
        chk("t4_grant3", 32'(last_ready), 32'b1000);
        v[3] = 1'b0;
        v[0] = 1'b1; l[0] = 1'b1;
        for (int k = 0; k < LT; k++) begin
            cycle();
            chk("t4_blocked", 32'(last_ready), 32'd0);
        end
        chk("t4_busy_held", 32'(busy), 32'd1);
        v[3] = 1'b1; l[3] = 1'b1;
        cycle();
        chk("t4_late_refused", 32'(last_ready),  32'd0);
        chk("t4_idle",         32'(dbg_state),   32'd0);
        chk("t4_terr",         32'(timeout_err), 32'd1);
        cycle();
        chk("t4_grant0", 32'(last_ready), 32'b0001);
        v[0] = 1'b0;
        cycle();
        v = '0;
        cycle();

        // Reset pulsed during the 2nd beat of a 5-beat burst from requester 2.
        do_reset();
        rem[2] = 5; load_beat(2, 1);
        cycle();
        rem[2]--; load_beat(2, 1);
        drive();
        #1;
        chk("t5_beat2_ready", 32'(bus.req_ready), 32'b0100);
        rst = 1'b0;
        #1;
        check_reset_values("t5_async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        v = '0; l = '0;
        v[0] = 1'b1; l[0] = 1'b1;
        v[2] = 1'b1; l[2] = 1'b1;
        cycle();
        chk("t5_grant0", 32'(last_ready), 32'b0001);
        v = '0;

        // drop_cnt saturation.
        do_reset();
        force dut.drop_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.drop_cnt_q;
        @(negedge clk);
        m_drop = 65535;
        v[1] = 1'b1; l[1] = 1'b1; px[1] = 9'd400; py[1] = 8'd10;
        cycle();
        chk("t6_sat", 32'(drop_cnt), 32'hFFFF);
        v = '0;

        // Randomized traffic from all requesters.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                if (m_acc == i) begin
                    rem[i]--;
                    if (rem[i] > 0) begin
                        if ($urandom_range(0, 4) == 0) v[i] = 1'b0;
                        else load_beat(i, 0);
                    end else v[i] = 1'b0;
                end else if (!v[i]) begin
                    if (rem[i] > 0) begin
                        if ($urandom_range(0, 1) == 0) load_beat(i, 0);
                    end else if ($urandom_range(0, 3) == 0) begin
                        rem[i] = $urandom_range(1, 5);
                        load_beat(i, 0);
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
